ms_task_scheduler: RTL

//  Periodic task scheduler driven by an internal 1 ms timebase. Each of NUM_TASKS

---
 rtl/ms_task_scheduler.sv | 204 ++++++++++++++++++++
 1 files changed

// File: rtl/ms_task_scheduler.sv
// ms_task_scheduler
//   Periodic task scheduler paced by an internal 1 ms timebase. Every channel
//   has a programmable period in ms. A channel that falls due is queued as
//   pending. One shared execution slot is handed out round-robin through a
//   one-cycle start pulse and a done handshake. The block also flags overruns
//   and timeouts per channel.
// Ports
//   clk_in          system clock
//   rst_n           synchronous reset, active-low
//   cfg_we          config write strobe
//   cfg_addr        channel index; writes to cfg_addr >= NUM_TASKS are ignored
//   cfg_period      period in ms, 0 disables the channel
//   task_start      one-cycle one-hot start pulse
//   task_done       done pulses from task logic; only the granted bit counts
//   busy            a task is granted and has not finished yet
//   active_id       index of the granted task, valid while busy
//   overrun_flag    sticky: channel fell due while still pending
//   timeout_flag    sticky: granted channel missed its done deadline
//   system_time_ms  free-running ms counter

// Per-channel period countdown and pending/overrun state.
module ms_task_channel #(
  parameter int PERIOD_W = 16
) (
  input  logic                clk_in,
  input  logic                rst_n,
  input  logic                tick,
  input  logic                wr,
  input  logic [PERIOD_W-1:0] wr_period,
  input  logic                grant_clr,
  output logic                pending,
  output logic                overrun
);
  logic [PERIOD_W-1:0] period, cnt;
  logic                due;

  assign due = tick && (period != '0) && (cnt == PERIOD_W'(1));

  always_ff @(posedge clk_in) begin
    if (!rst_n) begin
      period  <= '0;
      cnt     <= '0;
      pending <= 1'b0;
      overrun <= 1'b0;
    end else if (wr) begin
      // A write wins over a tick in the same cycle and restarts the countdown.
      period  <= wr_period;
      cnt     <= wr_period;
      pending <= 1'b0;
      overrun <= 1'b0;
    end else if (due) begin
      cnt     <= period;
      pending <= 1'b1;
      // Being granted this very cycle does not count as an overrun: the new
      // request simply replaces the one being consumed.
      if (pending && !grant_clr) overrun <= 1'b1;
    end else begin
      if (tick && (period != '0)) cnt <= cnt - PERIOD_W'(1);
      if (grant_clr) pending <= 1'b0;
    end
  end
endmodule

module ms_task_scheduler #(
  parameter int CLK_DIV    = 50000,
  parameter int NUM_TASKS  = 4,
  parameter int PERIOD_W   = 16,
  parameter int TIMEOUT_MS = 10
) (
  input  logic                 clk_in,
  input  logic                 rst_n,
  input  logic                 cfg_we,
  input  logic [2:0]           cfg_addr,
  input  logic [PERIOD_W-1:0]  cfg_period,
  output logic [NUM_TASKS-1:0] task_start,
  input  logic [NUM_TASKS-1:0] task_done,
  output logic                 busy,
  output logic [2:0]           active_id,
  output logic [NUM_TASKS-1:0] overrun_flag,
  output logic [NUM_TASKS-1:0] timeout_flag,
  output logic [31:0]          system_time_ms
);
  localparam int PW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam int TW = (TIMEOUT_MS > 1) ? $clog2(TIMEOUT_MS) : 1;

  typedef enum logic [1:0] {S_IDLE, S_GRANT, S_WAIT} state_t;

  state_t               state;
  logic [PW-1:0]        presc;
  logic                 tick;
  logic [TW-1:0]        to_cnt;
  logic [2:0]           last_id, pick;
  logic                 any_pend, done_act;
  logic [NUM_TASKS-1:0] pending, wr, grant_clr, act_oh, pick_oh;

  // ---------------- timebase ----------------
  assign tick = (presc == PW'(CLK_DIV - 1));

  always_ff @(posedge clk_in) begin
    if (!rst_n) begin
      presc          <= '0;
      system_time_ms <= '0;
    end else if (tick) begin
      presc          <= '0;
      system_time_ms <= system_time_ms + 32'd1;
    end else begin
      presc <= presc + PW'(1);
    end
  end

  // ---------------- channels ----------------
  for (genvar i = 0; i < NUM_TASKS; i++) begin : g_ch
    assign wr[i]        = cfg_we && (cfg_addr == 3'(i));
    assign grant_clr[i] = (state == S_GRANT) && act_oh[i];

    ms_task_channel #(.PERIOD_W(PERIOD_W)) u_ch (
      .clk_in    (clk_in),
      .rst_n     (rst_n),
      .tick      (tick),
      .wr        (wr[i]),
      .wr_period (cfg_period),
      .grant_clr (grant_clr[i]),
      .pending   (pending[i]),
      .overrun   (overrun_flag[i])
    );
  end

  // ---------------- round-robin pick ----------------
  // Distance d of channel i from last_id+1 (mod NUM_TASKS); the pending
  // channel with the smallest distance wins.
  always_comb begin
    int d, best_d;
    pick     = '0;
    best_d   = NUM_TASKS;
    d        = 0;
    any_pend = |pending;
    for (int i = 0; i < NUM_TASKS; i++) begin
      d = (i + 2 * NUM_TASKS - int'(last_id) - 1) % NUM_TASKS;
      if (pending[i] && (d < best_d)) begin
        best_d = d;
        pick   = 3'(i);
      end
    end
  end

  always_comb begin
    act_oh  = '0;
    pick_oh = '0;
    for (int i = 0; i < NUM_TASKS; i++) begin
      act_oh[i]  = (active_id == 3'(i));
      pick_oh[i] = (pick == 3'(i));
    end
  end

  assign done_act = |(task_done & act_oh);

  // ---------------- grant FSM ----------------
  always_ff @(posedge clk_in) begin
    if (!rst_n) begin
      state        <= S_IDLE;
      task_start   <= '0;
      busy         <= 1'b0;
      active_id    <= '0;
      last_id      <= 3'(NUM_TASKS - 1);
      to_cnt       <= '0;
      timeout_flag <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          task_start <= '0;
          if (any_pend) begin
            active_id  <= pick;
            task_start <= pick_oh;
            busy       <= 1'b1;
            state      <= S_GRANT;
          end
        end
        S_GRANT: begin
          task_start <= '0;
          to_cnt     <= '0;
          state      <= S_WAIT;
        end
        S_WAIT: begin
          // done beats a coincident timeout tick
          if (done_act) begin
            last_id <= active_id;
            busy    <= 1'b0;
            state   <= S_IDLE;
          end else if (tick) begin
            if (to_cnt == TW'(TIMEOUT_MS - 1)) begin
              timeout_flag <= timeout_flag | act_oh;
              last_id      <= active_id;
              busy         <= 1'b0;
              state        <= S_IDLE;
            end else begin
              to_cnt <= to_cnt + TW'(1);
            end
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end
endmodule
